// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// The CR/LF states are only entered when UART_TX_ARBITER_CRLF_EN is defined.
package uart_pkg;

  localparam int NBYTES_MAX_DEFAULT = 4;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    CR,
    LF,
    FINISH
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester that did not
// win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req0 | req1;
    gnt   = (req0 & req1) ? ~last_id : req1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-serial UART transmitter between two message sources.
// Define UART_TX_ARBITER_CRLF_EN to append CR, LF after every message.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NBYTES_MAX = NBYTES_MAX_DEFAULT,
  parameter int LENW       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic [LENW-1:0]         len0,
  input  logic [8*NBYTES_MAX-1:0] data0,
  output logic                    ack0,
  input  logic                    req1,
  input  logic [LENW-1:0]         len1,
  input  logic [8*NBYTES_MAX-1:0] data1,
  output logic                    ack1,
  output logic                    tstart,
  output logic [7:0]              tbus,
  input  logic                    tready,
  output logic                    busy,
  output logic                    gnt_id
);

  localparam int              BUFW    = 8*NBYTES_MAX;
  localparam logic [LENW-1:0] LEN_CAP = LENW'(NBYTES_MAX);

  state_t          state;
  logic [BUFW-1:0] buffer;
  logic [LENW-1:0] len;
  logic [LENW-1:0] idx;
  logic [LENW-1:0] sel_len;
  logic            arb_valid;
  logic            arb_id;
`ifdef UART_TX_ARBITER_CRLF_EN
  logic [1:0]      term;
`endif

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .last_id (gnt_id),
    .valid   (arb_valid),
    .gnt     (arb_id)
  );

  assign sel_len = arb_id ? len1 : len0;

  // The buffer shifts left after each byte, so the next byte is always at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      buffer <= '0;
      len    <= '0;
      idx    <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      tstart <= 1'b0;
      tbus   <= 8'h00;
      busy   <= 1'b0;
      gnt_id <= 1'b1;
`ifdef UART_TX_ARBITER_CRLF_EN
      term   <= 2'd0;
`endif
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      tstart <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            buffer <= arb_id ? data1 : data0;
            len    <= (sel_len > LEN_CAP) ? LEN_CAP : sel_len;
            idx    <= '0;
            ack0   <= ~arb_id;
            ack1   <= arb_id;
            busy   <= 1'b1;
            gnt_id <= arb_id;
            state  <= SEND;
`ifdef UART_TX_ARBITER_CRLF_EN
            term   <= 2'd0;
`endif
          end
        end
        SEND: begin
          if (idx == len) begin
`ifdef UART_TX_ARBITER_CRLF_EN
            state <= CR;
`else
            state <= FINISH;
`endif
          end else if (tready) begin
            tstart <= 1'b1;
            tbus   <= buffer[BUFW-1 -: 8];
            buffer <= buffer << 8;
            idx    <= idx + LENW'(1);
            state  <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!tready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tready) begin
`ifdef UART_TX_ARBITER_CRLF_EN
            case (term)
              2'd1:    state <= LF;
              2'd2:    state <= FINISH;
              default: state <= SEND;
            endcase
`else
            state <= SEND;
`endif
          end
        end
`ifdef UART_TX_ARBITER_CRLF_EN
        CR: begin
          if (tready) begin
            tstart <= 1'b1;
            tbus   <= ASCII_CR;
            term   <= 2'd1;
            state  <= WAIT_BUSY;
          end
        end
        LF: begin
          if (tready) begin
            tstart <= 1'b1;
            tbus   <= ASCII_LF;
            term   <= 2'd2;
            state  <= WAIT_BUSY;
          end
        end
`endif
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench for uart_tx_arbiter.
// Honours UART_TX_ARBITER_CRLF_EN to expect CR/LF terminators.
module tb_uart_tx_arbiter;

  localparam int NB = 4;
`ifdef UART_TX_ARBITER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req0, req1, ack0, ack1, tstart, tready, busy, gnt_id;
  logic [2:0]  len0, len1;
  logic [31:0] data0, data1;
  logic [7:0]  tbus;

  int checks = 0, failures = 0;
  logic [7:0] cap_q[$], exp_q[$];
  int ack_q[$];
  int rises = 0;
  int tx_drop = 1, tx_low = 3;
  bit tx_rand = 0;
  int last_gnt = 1;
  logic prev_tstart = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;

  uart_tx_arbiter #(.NBYTES_MAX(NB), .LENW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .len0(len0), .data0(data0), .ack0(ack0),
    .req1(req1), .len1(len1), .data1(data1), .ack1(ack1),
    .tstart(tstart), .tbus(tbus), .tready(tready),
    .busy(busy), .gnt_id(gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: ready drops after each strobe, stays low, then rises.
  initial begin
    int d, l;
    tready = 1'b1;
    forever begin
      @(negedge clk);
      if (tstart === 1'b1) begin
        d = tx_rand ? int'($urandom_range(1, 3)) : tx_drop;
        l = tx_rand ? int'($urandom_range(1, 8)) : tx_low;
        repeat (d - 1) @(negedge clk);
        tready = 1'b0;
        repeat (l) @(negedge clk);
        tready = 1'b1;
        rises++;
      end
    end
  end

  // Byte/ack logger with one-cycle pulse checks.
  initial begin
    forever begin
      @(negedge clk);
      if (tstart === 1'b1) begin
        cap_q.push_back(tbus);
        checks++;
        if (prev_tstart === 1'b1) begin
          failures++;
          $display("[TB] FAIL tstart_pulse got=2+ cycles exp=1 cycle");
        end
      end
      if (ack0 === 1'b1) ack_q.push_back(0);
      if (ack1 === 1'b1) ack_q.push_back(1);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        checks++;
        if ((ack0 && ack1) || (ack0 && prev_ack0) || (ack1 && prev_ack1)) begin
          failures++;
          $display("[TB] FAIL ack_pulse got ack0=%b ack1=%b prev0=%b prev1=%b exp single one-cycle pulse",
                   ack0, ack1, prev_ack0, prev_ack1);
        end
      end
      prev_tstart = tstart;
      prev_ack0   = ack0;
      prev_ack1   = ack1;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: bytes the transmitter must see for one message.
  function automatic void expect_msg(input logic [2:0] len, input logic [31:0] data);
    int n;
    n = (int'(len) > NB) ? NB : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(data[31-8*i -: 8]);
    if (CRLF) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic int sent_count(input logic [2:0] len);
    return (int'(len) > NB) ? NB : int'(len);
  endfunction

  // Busy duration with fixed transmitter timing (drop=1, low=L).
  function automatic int exp_busy(input int nbytes, input int l);
    return 2 + nbytes*(l+2) + (CRLF ? 2*l+4 : 0);
  endfunction

  function automatic logic [135:0] pack_q(input logic [7:0] q[$]);
    logic [135:0] r;
    r = '0;
    foreach (q[i]) r = {r[127:0], q[i]};
    r[135:128] = 8'(q.size());
    return r;
  endfunction

  function automatic int ack_code();
    int c;
    c = 0;
    foreach (ack_q[i]) c = c*4 + ack_q[i] + 1;
    return c;
  endfunction

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
    ack_q.delete();
    rises = 0;
  endtask

  task automatic wait_idle(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input int id, input logic [2:0] len, input logic [31:0] data,
                      output logic ack_seen, output logic gnt_seen, output int first_ts,
                      output int busy_cyc, output bit timeout);
    if (id == 0) begin req0 = 1'b1; len0 = len; data0 = data; end
    else         begin req1 = 1'b1; len1 = len; data1 = data; end
    @(negedge clk);
    ack_seen = (id == 0) ? ack0 : ack1;
    gnt_seen = gnt_id;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    first_ts = -1;
    busy_cyc = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (tstart === 1'b1 && first_ts < 0) first_ts = i;
      if (busy !== 1'b1) begin
        timeout = 1'b0;
        break;
      end
      busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    len0 = '0; len1 = '0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ack0 !== 1'b0)    begin failures++; $display("[TB] FAIL reset_ack0 got=%b exp=0", ack0); end
    if (ack1 !== 1'b0)    begin failures++; $display("[TB] FAIL reset_ack1 got=%b exp=0", ack1); end
    if (tstart !== 1'b0)  begin failures++; $display("[TB] FAIL reset_tstart got=%b exp=0", tstart); end
    if (tbus !== 8'h00)   begin failures++; $display("[TB] FAIL reset_tbus got=%h exp=00", tbus); end
    if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (gnt_id !== 1'b1)  begin failures++; $display("[TB] FAIL reset_gnt_id got=%b exp=1", gnt_id); end
    rst_n = 1'b1;
    last_gnt = 1;
    @(negedge clk);
  endtask

  task automatic test_tie();
    bit to;
    bit got1;
    clear_logs();
    tx_rand = 0; tx_drop = 1; tx_low = 3;
    req0 = 1'b1; len0 = 3'd1; data0 = {8'h41, 24'($urandom)};
    req1 = 1'b1; len1 = 3'd1; data1 = {8'h42, 24'($urandom)};
    expect_msg(3'd1, data0);
    expect_msg(3'd1, data1);
    @(negedge clk);
    checks += 2;
    if (ack0 !== 1'b1) begin failures++; $display("[TB] FAIL tie_ack0 got=%b exp=1", ack0); end
    if (ack1 !== 1'b0) begin failures++; $display("[TB] FAIL tie_ack1 got=%b exp=0", ack1); end
    req0 = 1'b0;
    got1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ack1 === 1'b1) begin got1 = 1'b1; break; end
    end
    req1 = 1'b0;
    wait_idle(to);
    checks += 3;
    if (!got1 || to) begin failures++; $display("[TB] FAIL tie_timeout got ack1=%b stuck=%b exp ack1=1 stuck=0", got1, to); end
    if (ack_code() !== 6) begin failures++; $display("[TB] FAIL tie_order got=%0d exp=6", ack_code()); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL tie_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    last_gnt = 1;
  endtask

  task automatic test_alternate();
    int nacks, start, code, id;
    bit to;
    logic [31:0] d0, d1;
    clear_logs();
    d0 = $urandom; d1 = $urandom;
    start = 1 - last_gnt;
    code = 0;
    for (int k = 0; k < 4; k++) begin
      id = start ^ (k % 2);
      code = code*4 + id + 1;
      expect_msg(3'd1, id ? d1 : d0);
    end
    req0 = 1'b1; req1 = 1'b1; len0 = 3'd1; len1 = 3'd1; data0 = d0; data1 = d1;
    nacks = 0;
    for (int i = 0; i < 3000 && nacks < 4; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) nacks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(to);
    checks += 3;
    if (nacks !== 4 || to) begin failures++; $display("[TB] FAIL alt_count got=%0d stuck=%b exp=4 stuck=0", nacks, to); end
    if (ack_code() !== code) begin failures++; $display("[TB] FAIL alt_order got=%0d exp=%0d", ack_code(), code); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL alt_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    last_gnt = start ^ 1;
  endtask

  task automatic test_single();
    logic a, g;
    int fts, bc;
    bit to;
    logic [31:0] d;
    clear_logs();
    tx_rand = 0; tx_drop = 1; tx_low = 10;
    d = {16'h4631, 16'($urandom)};
    expect_msg(3'd2, d);
    send(0, 3'd2, d, a, g, fts, bc, to);
    checks += 7;
    if (a !== 1'b1)  begin failures++; $display("[TB] FAIL single_ack got=%b exp=1", a); end
    if (g !== 1'b0)  begin failures++; $display("[TB] FAIL single_gnt got=%b exp=0", g); end
    if (fts !== 1)   begin failures++; $display("[TB] FAIL single_first_tstart got=%0d exp=1", fts); end
    if (to)          begin failures++; $display("[TB] FAIL single_timeout got=stuck exp=idle"); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL single_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    if (rises !== exp_q.size()) begin failures++; $display("[TB] FAIL single_ready_rises got=%0d exp=%0d", rises, exp_q.size()); end
    if (bc !== exp_busy(2, 10)) begin failures++; $display("[TB] FAIL single_busy got=%0d exp=%0d", bc, exp_busy(2, 10)); end
    last_gnt = 0;
  endtask

  task automatic test_len0_and_clamp();
    logic a, g;
    int fts, bc;
    bit to;
    logic [31:0] d;
    tx_rand = 0; tx_drop = 1; tx_low = 3;
    clear_logs();
    d = $urandom;
    expect_msg(3'd0, d);
    send(1, 3'd0, d, a, g, fts, bc, to);
    checks += 4;
    if (a !== 1'b1 || to) begin failures++; $display("[TB] FAIL len0_ack got=%b stuck=%b exp=1 stuck=0", a, to); end
    if (g !== 1'b1) begin failures++; $display("[TB] FAIL len0_gnt got=%b exp=1", g); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL len0_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    if (bc !== exp_busy(0, 3)) begin failures++; $display("[TB] FAIL len0_busy got=%0d exp=%0d", bc, exp_busy(0, 3)); end
    clear_logs();
    d = $urandom;
    expect_msg(3'd7, d);
    send(0, 3'd7, d, a, g, fts, bc, to);
    checks += 3;
    if (a !== 1'b1 || to) begin failures++; $display("[TB] FAIL clamp_ack got=%b stuck=%b exp=1 stuck=0", a, to); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL clamp_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    if (bc !== exp_busy(sent_count(3'd7), 3)) begin
      failures++; $display("[TB] FAIL clamp_busy got=%0d exp=%0d", bc, exp_busy(sent_count(3'd7), 3));
    end
    last_gnt = 0;
  endtask

  task automatic test_busy_req();
    bit to, got1;
    logic bprev;
    logic [31:0] da, db;
    tx_rand = 0; tx_drop = 1; tx_low = 4;
    // A request withdrawn while busy must never be acknowledged.
    clear_logs();
    da = $urandom;
    expect_msg(3'd2, da);
    req0 = 1'b1; len0 = 3'd2; data0 = da;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; len1 = 3'd1; data1 = $urandom;
    repeat (3) @(negedge clk);
    req1 = 1'b0;
    wait_idle(to);
    repeat (3) @(negedge clk);
    #1;
    checks += 2;
    if (to || ack_code() !== 1) begin failures++; $display("[TB] FAIL drop_ignored got=%0d stuck=%b exp=1 stuck=0", ack_code(), to); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL drop_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    // A request held while busy is granted only after an idle cycle.
    clear_logs();
    da = $urandom; db = $urandom;
    expect_msg(3'd1, da);
    expect_msg(3'd1, db);
    req0 = 1'b1; len0 = 3'd1; data0 = da;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; len1 = 3'd1; data1 = db;
    bprev = busy;
    got1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ack1 === 1'b1) begin got1 = 1'b1; break; end
      bprev = busy;
    end
    req1 = 1'b0;
    wait_idle(to);
    checks += 3;
    if (!got1 || to) begin failures++; $display("[TB] FAIL pend_ack got=%b stuck=%b exp=1 stuck=0", got1, to); end
    if (bprev !== 1'b0) begin failures++; $display("[TB] FAIL pend_gap got busy_before_ack=%b exp=0", bprev); end
    if (pack_q(cap_q) !== pack_q(exp_q) || ack_code() !== 6) begin
      failures++; $display("[TB] FAIL pend_bytes got=%h acks=%0d exp=%h acks=6", pack_q(cap_q), ack_code(), pack_q(exp_q));
    end
    last_gnt = 1;
  endtask

  task automatic test_abort();
    logic a, g;
    int fts, bc;
    bit to, low_seen;
    logic [31:0] d;
    tx_rand = 0; tx_drop = 1; tx_low = 10;
    clear_logs();
    req0 = 1'b1; len0 = 3'd3; data0 = $urandom;
    @(negedge clk);
    req0 = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tready === 1'b0) begin low_seen = 1'b1; break; end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (!low_seen)       begin failures++; $display("[TB] FAIL abort_setup got=no ready drop exp=drop"); end
    if (tstart !== 1'b0) begin failures++; $display("[TB] FAIL abort_tstart got=%b exp=0", tstart); end
    if (busy !== 1'b0)   begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("[TB] FAIL abort_ack got=%b%b exp=00", ack0, ack1); end
    if (gnt_id !== 1'b1) begin failures++; $display("[TB] FAIL abort_gnt got=%b exp=1", gnt_id); end
    if (tbus !== 8'h00)  begin failures++; $display("[TB] FAIL abort_tbus got=%h exp=00", tbus); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50 && tready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    clear_logs();
    d = $urandom;
    expect_msg(3'd1, d);
    send(1, 3'd1, d, a, g, fts, bc, to);
    checks += 3;
    if (a !== 1'b1 || to) begin failures++; $display("[TB] FAIL abort_resume_ack got=%b stuck=%b exp=1 stuck=0", a, to); end
    if (g !== 1'b1) begin failures++; $display("[TB] FAIL abort_resume_gnt got=%b exp=1", g); end
    if (pack_q(cap_q) !== pack_q(exp_q)) begin
      failures++; $display("[TB] FAIL abort_resume_bytes got=%h exp=%h", pack_q(cap_q), pack_q(exp_q));
    end
    last_gnt = 1;
  endtask

  task automatic test_random();
    logic a, g;
    int fts, bc, id;
    bit to;
    logic [2:0] len;
    logic [31:0] d;
    tx_rand = 1;
    for (int k = 0; k < 12; k++) begin
      clear_logs();
      id  = int'($urandom_range(0, 1));
      len = 3'($urandom_range(0, 7));
      d   = $urandom;
      expect_msg(len, d);
      send(id, len, d, a, g, fts, bc, to);
      checks += 3;
      if (a !== 1'b1 || g !== 1'(id) || to) begin
        failures++; $display("[TB] FAIL rand_ack[%0d] got ack=%b gnt=%b stuck=%b exp ack=1 gnt=%0d stuck=0", k, a, g, to, id);
      end
      if (pack_q(cap_q) !== pack_q(exp_q)) begin
        failures++; $display("[TB] FAIL rand_bytes[%0d] got=%h exp=%h", k, pack_q(cap_q), pack_q(exp_q));
      end
      if (rises !== exp_q.size()) begin
        failures++; $display("[TB] FAIL rand_rises[%0d] got=%0d exp=%0d", k, rises, exp_q.size());
      end
      last_gnt = id;
    end
    tx_rand = 0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_alternate();
    test_single();
    test_len0_and_clamp();
    test_busy_req();
    test_abort();
    test_random();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
